// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;

  // Debounce counter width: never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_p <= '0;
    else          sync_p <= {sync_p[STAGES-2:0], d};
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw push-button, producing a clean level,
// one-cycle press/release pulses and a toggle output.
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle_q,
  output logic busy
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             btn_sync;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, release_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (btn_sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle_q      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      toggle_q      <= toggle_q ^ press_nxt;
    end
  end

  // A check state returns to its stable origin on any opposing sample.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      RELEASED: begin
        if (btn_sync) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_sync) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    btn_level = (state == PRESSED) || (state == RELEASE_CHK);
    busy      = (state == PRESS_CHK) || (state == RELEASE_CHK);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length
// reference model of the synchronizer delay and debounce acceptance rule.
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, toggle_q, busy;

  button_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .toggle_q      (toggle_q),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [SYNC-1:0] m_dly;
  int   m_run;
  logic m_level, m_toggle, m_press, m_rel;

  int tick_no, press_cnt, rel_cnt, press_tick, rel_tick;
  logic seen_busy;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dly = '0; m_run = 0; m_level = 0; m_toggle = 0; m_press = 0; m_rel = 0;
  endtask

  // Level flips once DEB+1 consecutive delayed samples oppose it.
  task automatic model_step(input logic raw);
    logic s;
    s = m_dly[SYNC-1];
    m_dly = {m_dly[SYNC-2:0], raw};
    m_press = 0; m_rel = 0;
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = ~m_level;
        if (m_level) begin m_press = 1; m_toggle = ~m_toggle; end
        else         m_rel = 1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".btn_level"},     btn_level,     m_level);
    check({ctx, ".press_pulse"},   press_pulse,   m_press);
    check({ctx, ".release_pulse"}, release_pulse, m_rel);
    check({ctx, ".toggle_q"},      toggle_q,      m_toggle);
    check({ctx, ".busy"},          busy,          (m_run != 0));
  endtask

  task automatic tick(input logic raw);
    btn_raw = raw;
    @(posedge clk);
    tick_no++;
    model_step(raw);
    #1;
    check_all("cyc");
    if (busy) seen_busy = 1;
    if (press_pulse) begin press_cnt++; press_tick = tick_no; end
    if (release_pulse) begin rel_cnt++; rel_tick = tick_no; end
  endtask

  task automatic do_reset(input logic raw);
    btn_raw = raw;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    reset_n = 1'b1;
    tick_no = 0; press_cnt = 0; rel_cnt = 0;
    press_tick = -1; rel_tick = -1; seen_busy = 0;
  endtask

  initial begin
    int len;
    logic v;
    int t_press;

    // Reset with the button already held
    @(posedge clk); #1;
    do_reset(1'b1);
    repeat (10) tick(1'b1);
    check("rst_press_edge", press_tick, 7);
    check("rst_toggle", toggle_q, 1);
    check("rst_level", btn_level, 1);
    tick_no = 0;
    repeat (12) tick(1'b0);
    check("rst_release_edge", rel_tick, 7);

    // Clean press and release
    do_reset(1'b0);
    repeat (3) tick(1'b0);
    seen_busy = 0;
    repeat (20) tick(1'b1);
    check("clean_press_cnt", press_cnt, 1);
    check("clean_busy_press", seen_busy, 1);
    seen_busy = 0;
    repeat (20) tick(1'b0);
    check("clean_rel_cnt", rel_cnt, 1);
    check("clean_busy_rel", seen_busy, 1);

    // Bounce on the way in
    do_reset(1'b0);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1);
    repeat (24) tick(1'b1);
    check("bounce_press_edge", press_tick, 12);
    check("bounce_press_cnt", press_cnt, 1);

    // Three press/release pairs
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (12) tick(1'b1);
      check("toggle_seq", toggle_q, (i % 2 == 0) ? 1 : 0);
      repeat (12) tick(1'b0);
    end
    check("toggle_press_cnt", press_cnt, 3);
    check("toggle_rel_cnt", rel_cnt, 3);

    // Reset in the middle of a press check
    do_reset(1'b0);
    repeat (3) tick(1'b1);
    check("midchk_busy", busy, 1);
    do_reset(1'b0);
    repeat (15) tick(1'b0);
    check("midchk_press_cnt", press_cnt, 0);
    check("midchk_level", btn_level, 0);

    // Long hold
    do_reset(1'b0);
    repeat (2) tick(1'b0);
    repeat (100) tick(1'b1);
    check("hold_press_cnt", press_cnt, 1);
    check("hold_level", btn_level, 1);
    check("hold_busy", busy, 0);

    // Random bouncing segments
    do_reset(1'b0);
    for (int seg = 0; seg < 200; seg++) begin
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(6, 15);
      else                           len = $urandom_range(1, 4);
      repeat (len) tick(v);
    end
    t_press = press_cnt;
    repeat (12) tick(1'b0);
    check("rand_final_level", btn_level, 0);
    check("rand_no_extra_press", press_cnt, t_press);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
